// File: rtl/spi_word_pkg.sv
// Shared definitions for the SPI word controller: controller state encoding,
// the default word width and the serial bit-order mapping.
package spi_word_pkg;

    localparam int DEFAULT_WORD_BITS = 64;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        GAP,
        HELD
    } state_t;

    // Serial bit n travels LSB-byte first, MSB first within each byte.
    function automatic int unsigned bit_index(input int unsigned n);
        return 8 * (n / 8) + 7 - (n % 8);
    endfunction

endpackage

// File: rtl/spi_word_controller_sck_gen.sv
// SCK generator: a CLK_DIV half-period counter producing SCK and
// single-cycle strobes that flag the clock edge on which SCK will rise or fall.
module spi_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic CLK,
    input  logic resetn,
    input  logic enable,
    input  logic clear,
    output logic sck,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] count;
    logic             terminal;

    assign terminal = (count == CNT_W'(CLK_DIV - 1));
    assign rise     = enable && terminal && !sck;
    assign fall     = enable && terminal && sck;

    // Count out each half period and toggle SCK at its end; clear parks SCK low.
    always_ff @(posedge CLK) begin
        if (!resetn || clear) begin
            count <= '0;
            sck   <= 1'b0;
        end else if (enable) begin
            if (terminal) begin
                count <= '0;
                sck   <= ~sck;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/spi_word_controller.sv
// SPI mode-0 initiator moving one little-endian word per CS frame while
// capturing the returned word. Optional burst mode (macro
// SPI_WORD_CONTROLLER_BURST_EN) adds tx_hold to keep CS low between words.
module spi_word_controller
    import spi_word_pkg::*;
#(
    parameter int WORD_BITS = DEFAULT_WORD_BITS,
    parameter int CLK_DIV   = 4,
    parameter int CS_SETUP  = 2,
    parameter int CS_HOLD   = 2
) (
    input  logic                 CLK,
    input  logic                 resetn,
    input  logic [WORD_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [WORD_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 busy,
    output logic                 SCK,
    output logic                 CS,
    output logic                 COPI,
    input  logic                 CIPO
`ifdef SPI_WORD_CONTROLLER_BURST_EN
    ,
    input  logic                 tx_hold
`endif
);

    localparam int IDX_W   = $clog2(WORD_BITS);
    localparam int PHASE_W = 16;

    state_t               state;
    state_t               state_next;
    logic [PHASE_W-1:0]   phase_cnt;
    logic [IDX_W-1:0]     bit_cnt;
    logic [WORD_BITS-1:0] tx_word;
    logic [WORD_BITS-1:0] rx_word;
    logic                 accept;
    logic                 last_bit;
    logic                 chain;
    logic                 sck_rise;
    logic                 sck_fall;
    logic                 sck_en;
    logic                 sck_clr;
    logic [IDX_W-1:0]     first_sel;
    logic [IDX_W-1:0]     cur_sel;
    logic [IDX_W-1:0]     next_sel;

`ifdef SPI_WORD_CONTROLLER_BURST_EN
    logic hold_word;

    assign chain    = hold_word;
    assign tx_ready = (state == IDLE) || (state == HELD);
`else
    assign chain    = 1'b0;
    assign tx_ready = (state == IDLE);
`endif

    assign busy      = (state != IDLE);
    assign accept    = tx_valid && tx_ready;
    assign last_bit  = (bit_cnt == IDX_W'(WORD_BITS - 1));
    assign sck_en    = (state == XFER);
    assign sck_clr   = (state != XFER);
    assign first_sel = IDX_W'(bit_index(32'd0));
    assign cur_sel   = IDX_W'(bit_index(32'(bit_cnt)));
    assign next_sel  = IDX_W'(bit_index(32'(bit_cnt) + 32'd1));

    spi_sck_gen #(
        .CLK_DIV(CLK_DIV)
    ) sck_gen (
        .CLK   (CLK),
        .resetn(resetn),
        .enable(sck_en),
        .clear (sck_clr),
        .sck   (SCK),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; SETUP/HOLD/GAP are timed by the phase counter.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tx_valid) state_next = SETUP;
            SETUP:   if (phase_cnt == PHASE_W'(CS_SETUP - 1)) state_next = XFER;
            XFER:    if (sck_fall && last_bit) state_next = chain ? HELD : HOLD;
            HOLD:    if (phase_cnt == PHASE_W'(CS_HOLD - 1)) state_next = GAP;
            GAP:     if (phase_cnt == PHASE_W'(CLK_DIV - 1)) state_next = IDLE;
            HELD:    if (tx_valid) state_next = XFER;
            default: state_next = IDLE;
        endcase
    end

    // Phase counter restarts on every state change.
    always_ff @(posedge CLK) begin
        if (!resetn || (state_next != state)) begin
            phase_cnt <= '0;
        end else begin
            phase_cnt <= phase_cnt + PHASE_W'(1);
        end
    end

    // Shift datapath, registered CS/COPI and the completion pulse.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            tx_word  <= '0;
            rx_word  <= '0;
            bit_cnt  <= '0;
            CS       <= 1'b1;
            COPI     <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
`ifdef SPI_WORD_CONTROLLER_BURST_EN
            hold_word <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
            CS       <= !(state_next inside {SETUP, XFER, HOLD, HELD});
            if (accept) begin
                tx_word <= tx_data;
                bit_cnt <= '0;
                COPI    <= tx_data[first_sel];
`ifdef SPI_WORD_CONTROLLER_BURST_EN
                hold_word <= tx_hold;
`endif
            end
            if ((state == XFER) && sck_rise) begin
                rx_word[cur_sel] <= CIPO;
            end
            if ((state == XFER) && sck_fall && !last_bit) begin
                bit_cnt <= bit_cnt + IDX_W'(1);
                COPI    <= tx_word[next_sel];
            end
            if ((state == HOLD) && (state_next == GAP)) begin
                COPI     <= 1'b0;
                rx_valid <= 1'b1;
                rx_data  <= rx_word;
            end
            if ((state == XFER) && (state_next == HELD)) begin
                rx_valid <= 1'b1;
                rx_data  <= rx_word;
            end
        end
    end

endmodule

// File: tb/tb_spi_word_controller.sv
// Bench for spi_word_controller: a CLK_DIV=2 instance (loopback or peripheral
// model on CIPO) and a CLK_DIV=1 loopback instance, with a received-word scoreboard.
module tb_spi_word_controller;

    logic        CLK = 1'b0;
    logic        resetn;

    logic [63:0] tx_data_a, rx_data_a;
    logic        tx_valid_a, tx_ready_a, rx_valid_a, busy_a, sck_a, cs_a, copi_a, cipo_a;
    logic        tx_hold_a;
    logic [63:0] tx_data_b, rx_data_b;
    logic        tx_valid_b, tx_ready_b, rx_valid_b, busy_b, sck_b, cs_b, copi_b;
    logic        tx_hold_b;

    logic        cipo_sel;
    logic [63:0] per_word;
    int          per_count;
    logic        per_bit;

    logic [63:0] exp_a[$];
    logic [63:0] exp_b[$];
    logic [63:0] popped_a, popped_b;

    int          errors = 0;
    int          checks = 0;
    int          cs_sck_viol = 0;

    always #5 CLK = ~CLK;

    spi_word_controller #(.WORD_BITS(64), .CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2)) dut_a (
        .CLK(CLK), .resetn(resetn), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
        .tx_ready(tx_ready_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a), .busy(busy_a),
        .SCK(sck_a), .CS(cs_a), .COPI(copi_a), .CIPO(cipo_a)
`ifdef SPI_WORD_CONTROLLER_BURST_EN
        , .tx_hold(tx_hold_a)
`endif
    );

    spi_word_controller #(.WORD_BITS(64), .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) dut_b (
        .CLK(CLK), .resetn(resetn), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
        .tx_ready(tx_ready_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b), .busy(busy_b),
        .SCK(sck_b), .CS(cs_b), .COPI(copi_b), .CIPO(copi_b)
`ifdef SPI_WORD_CONTROLLER_BURST_EN
        , .tx_hold(tx_hold_b)
`endif
    );

    assign cipo_a = cipo_sel ? per_bit : copi_a;

    // Mode-0 peripheral: first bit ready when CS falls, next bit after each SCK fall.
    initial per_count = 0;
    always @(negedge sck_a or posedge cs_a) begin
        if (cs_a === 1'b1) per_count = 0;
        else               per_count = per_count + 1;
    end

    always_comb begin
        per_bit = 1'b0;
        if (per_count < 64) per_bit = per_word[8 * (per_count / 8) + 7 - (per_count % 8)];
    end

    // Scoreboards: every rx_valid pulse must match the oldest outstanding word.
    always @(posedge CLK) begin
        #1;
        if (resetn === 1'b1 && rx_valid_a === 1'b1) begin
            checks++;
            if (exp_a.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_a_unexpected: rx_valid with rx_data=%h, required no pulse", rx_data_a);
            end else begin
                popped_a = exp_a.pop_front();
                if (rx_data_a !== popped_a) begin
                    errors++;
                    $display("[TB] FAIL sb_a_data: rx_data=%h, required %h", rx_data_a, popped_a);
                end
            end
        end
        if (resetn === 1'b1 && rx_valid_b === 1'b1) begin
            checks++;
            if (exp_b.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_b_unexpected: rx_valid with rx_data=%h, required no pulse", rx_data_b);
            end else begin
                popped_b = exp_b.pop_front();
                if (rx_data_b !== popped_b) begin
                    errors++;
                    $display("[TB] FAIL sb_b_data: rx_data=%h, required %h", rx_data_b, popped_b);
                end
            end
        end
        if ((cs_a === 1'b1 && sck_a === 1'b1) || (cs_b === 1'b1 && sck_b === 1'b1)) cs_sck_viol++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drives one word into the selected DUT and watches it until rx_valid.
    task automatic transfer(input bit sel, input logic [63:0] word, input logic [63:0] expect_rx,
                            output int latency, output int rises, output logic [63:0] serial,
                            output bit copi_high);
        int   wait_n;
        logic prev_sck, s_sck, s_cs, s_copi, s_rxv;
        wait_n = 0;
        while ((sel ? tx_ready_b : tx_ready_a) !== 1'b1 && wait_n < 200) begin
            tick();
            wait_n++;
        end
        if (wait_n >= 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_wait: tx_ready=%b after 200 cycles, required 1", sel ? tx_ready_b : tx_ready_a);
        end
        if (sel) begin
            tx_data_b = word; tx_valid_b = 1'b1; exp_b.push_back(expect_rx);
        end else begin
            tx_data_a = word; tx_valid_a = 1'b1; exp_a.push_back(expect_rx);
        end
        rises = 0; serial = '0; copi_high = 0; prev_sck = 1'b0;
        tick();
        latency = 1;
        tx_valid_a = 1'b0;
        tx_valid_b = 1'b0;
        while (latency < 5000) begin
            s_sck  = sel ? sck_b : sck_a;
            s_cs   = sel ? cs_b : cs_a;
            s_copi = sel ? copi_b : copi_a;
            s_rxv  = sel ? rx_valid_b : rx_valid_a;
            if (s_cs === 1'b0 && s_sck === 1'b1 && prev_sck === 1'b0) begin
                if (rises < 64) serial[rises] = s_copi;
                rises++;
            end
            if (s_cs === 1'b0 && s_copi === 1'b1) copi_high = 1;
            prev_sck = s_sck;
            if (s_rxv === 1'b1) break;
            tick();
            latency++;
        end
        if (latency >= 5000) begin
            checks++;
            errors++;
            $display("[TB] FAIL rx_timeout: no rx_valid within 5000 cycles, required a pulse");
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) tick();
        checks++;
        if ({cs_a, sck_a, copi_a, rx_valid_a, busy_a, tx_ready_a} !== 6'b100001) begin
            errors++;
            $display("[TB] FAIL reset_a_ctrl: {CS,SCK,COPI,rx_valid,busy,tx_ready}=%b, required 100001",
                     {cs_a, sck_a, copi_a, rx_valid_a, busy_a, tx_ready_a});
        end
        checks++;
        if (rx_data_a !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset_a_rx: rx_data=%h, required 0", rx_data_a);
        end
        checks++;
        if ({cs_b, sck_b, copi_b, rx_valid_b, busy_b, tx_ready_b} !== 6'b100001) begin
            errors++;
            $display("[TB] FAIL reset_b_ctrl: {CS,SCK,COPI,rx_valid,busy,tx_ready}=%b, required 100001",
                     {cs_b, sck_b, copi_b, rx_valid_b, busy_b, tx_ready_b});
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_loopback();
        int          lat, rises;
        logic [63:0] ser, exp_ser, w;
        logic [7:0]  first_byte;
        bit          hi;
        w = 64'h0123456789ABCDEF;
        cipo_sel = 1'b0;
        transfer(0, w, w, lat, rises, ser, hi);
        for (int i = 0; i < 8; i++) first_byte[7 - i] = ser[i];
        for (int n = 0; n < 64; n++) exp_ser[n] = w[8 * (n / 8) + 7 - (n % 8)];
        checks++;
        if (first_byte !== 8'hEF) begin
            errors++;
            $display("[TB] FAIL loop_first_byte: got %h, required ef", first_byte);
        end
        checks++;
        if (ser !== exp_ser) begin
            errors++;
            $display("[TB] FAIL loop_serial: got %h, required %h", ser, exp_ser);
        end
        checks++;
        if (lat != 261) begin
            errors++;
            $display("[TB] FAIL loop_latency: got %0d, required 261", lat);
        end
        checks++;
        if (rises != 64) begin
            errors++;
            $display("[TB] FAIL loop_rises: got %0d, required 64", rises);
        end
        tick();
        checks++;
        if (rx_valid_a !== 1'b0 || rx_data_a !== w) begin
            errors++;
            $display("[TB] FAIL loop_pulse_hold: rx_valid=%b rx_data=%h, required 0 and %h", rx_valid_a, rx_data_a, w);
        end
    endtask

    task automatic test_peripheral();
        int          lat, rises;
        logic [63:0] ser;
        bit          hi;
        per_word = 64'hFEDCBA9876543210;
        cipo_sel = 1'b1;
        transfer(0, 64'h0, 64'hFEDCBA9876543210, lat, rises, ser, hi);
        checks++;
        if (hi != 0) begin
            errors++;
            $display("[TB] FAIL periph_copi: COPI went high=%0d, required 0", hi);
        end
        checks++;
        if (rises != 64) begin
            errors++;
            $display("[TB] FAIL periph_rises: got %0d, required 64", rises);
        end
        checks++;
        if (rx_data_a !== 64'hFEDCBA9876543210) begin
            errors++;
            $display("[TB] FAIL periph_rx: got %h, required fedcba9876543210", rx_data_a);
        end
        cipo_sel = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int pulses, gap, viol, cyc;
        bit started2;
        pulses = 0; gap = 0; viol = 0; started2 = 0;
        tx_data_a = 64'h1122334455667788;
        tx_valid_a = 1'b1;
        exp_a.push_back(64'h1122334455667788);
        tick();
        for (cyc = 0; cyc < 2000; cyc++) begin
            if (cyc == 100) begin
                tx_data_a = 64'h99AABBCCDDEEFF00;
                exp_a.push_back(64'h99AABBCCDDEEFF00);
            end
            if (busy_a === 1'b1 && tx_ready_a === 1'b1) viol++;
            if (rx_valid_a === 1'b1) pulses++;
            if (pulses == 1 && !started2) begin
                if (cs_a === 1'b1) gap++;
                else if (gap > 0) begin
                    started2 = 1;
                    tx_valid_a = 1'b0;
                end
            end
            if (pulses == 2) break;
            tick();
        end
        tx_valid_a = 1'b0;
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("[TB] FAIL b2b_pulses: got %0d, required 2", pulses);
        end
        checks++;
        if (gap < 2) begin
            errors++;
            $display("[TB] FAIL b2b_gap: CS high for %0d cycles, required >= 2", gap);
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("[TB] FAIL b2b_ready_busy: tx_ready high while busy in %0d cycles, required 0", viol);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        int          rises, pulses, lat, r2;
        logic        prev_sck;
        logic [63:0] ser;
        bit          hi;
        rises = 0; pulses = 0; prev_sck = 1'b0;
        tx_data_a = 64'h5A5A5A5A12345678;
        tx_valid_a = 1'b1;
        exp_a.push_back(64'h5A5A5A5A12345678);
        tick();
        tx_valid_a = 1'b0;
        for (int i = 0; i < 1000 && rises < 21; i++) begin
            if (cs_a === 1'b0 && sck_a === 1'b1 && prev_sck === 1'b0) rises++;
            prev_sck = sck_a;
            if (rises < 21) tick();
        end
        exp_a.delete();
        resetn = 1'b0;
        tick();
        checks++;
        if ({cs_a, sck_a, copi_a, tx_ready_a} !== 4'b1001) begin
            errors++;
            $display("[TB] FAIL abort_ctrl: {CS,SCK,COPI,tx_ready}=%b, required 1001", {cs_a, sck_a, copi_a, tx_ready_a});
        end
        checks++;
        if (rx_data_a !== 64'h0 || rx_valid_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_rx: rx_valid=%b rx_data=%h, required 0 and 0", rx_valid_a, rx_data_a);
        end
        resetn = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (rx_valid_a === 1'b1) pulses++;
            tick();
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("[TB] FAIL abort_no_pulse: got %0d pulses, required 0", pulses);
        end
        transfer(0, 64'hC3C3000011112222, 64'hC3C3000011112222, lat, r2, ser, hi);
        checks++;
        if (lat != 261) begin
            errors++;
            $display("[TB] FAIL abort_retry_latency: got %0d, required 261", lat);
        end
        tick();
    endtask

    task automatic test_fast();
        int          lat, rises;
        logic [63:0] ser, exp_ser, w;
        bit          hi;
        w = 64'hAAAA5555AAAA5555;
        transfer(1, w, w, lat, rises, ser, hi);
        for (int n = 0; n < 64; n++) exp_ser[n] = w[8 * (n / 8) + 7 - (n % 8)];
        checks++;
        if (lat != 131) begin
            errors++;
            $display("[TB] FAIL fast_latency: got %0d, required 131", lat);
        end
        checks++;
        if (rises != 64) begin
            errors++;
            $display("[TB] FAIL fast_rises: got %0d, required 64", rises);
        end
        checks++;
        if (ser !== exp_ser) begin
            errors++;
            $display("[TB] FAIL fast_serial: got %h, required %h", ser, exp_ser);
        end
        tick();
    endtask

`ifdef SPI_WORD_CONTROLLER_BURST_EN
    task automatic test_burst();
        int   n, first_rise, cs_high;
        logic prev_sck;
        cs_high = 0; first_rise = -1; prev_sck = 1'b0;
        tx_data_a = 64'h0F1E2D3C4B5A6978;
        tx_hold_a = 1'b1;
        tx_valid_a = 1'b1;
        exp_a.push_back(64'h0F1E2D3C4B5A6978);
        tick();
        tx_valid_a = 1'b0;
        for (n = 0; n < 1000 && rx_valid_a !== 1'b1; n++) begin
            if (cs_a === 1'b1) cs_high++;
            tick();
        end
        checks++;
        if ({rx_valid_a, cs_a, tx_ready_a, busy_a} !== 4'b1011) begin
            errors++;
            $display("[TB] FAIL burst_held: {rx_valid,CS,tx_ready,busy}=%b, required 1011", {rx_valid_a, cs_a, tx_ready_a, busy_a});
        end
        tx_data_a = 64'h8796A5B4C3D2E1F0;
        tx_hold_a = 1'b0;
        tx_valid_a = 1'b1;
        exp_a.push_back(64'h8796A5B4C3D2E1F0);
        tick();
        tx_valid_a = 1'b0;
        for (n = 1; n < 1000; n++) begin
            if (cs_a === 1'b0 && sck_a === 1'b1 && prev_sck === 1'b0 && first_rise < 0) first_rise = n;
            prev_sck = sck_a;
            if (rx_valid_a === 1'b1) break;
            if (cs_a === 1'b1) cs_high++;
            tick();
        end
        checks++;
        if (first_rise != 3) begin
            errors++;
            $display("[TB] FAIL burst_no_setup: first rise at %0d, required 3", first_rise);
        end
        checks++;
        if (n != 259) begin
            errors++;
            $display("[TB] FAIL burst_latency: got %0d, required 259", n);
        end
        checks++;
        if (cs_high != 0 || cs_a !== 1'b1) begin
            errors++;
            $display("[TB] FAIL burst_cs: CS high %0d cycles, CS at end=%b, required 0 and 1", cs_high, cs_a);
        end
        tick();
    endtask
`endif

    task automatic test_final();
        repeat (5) tick();
        checks++;
        if (cs_sck_viol != 0) begin
            errors++;
            $display("[TB] FAIL sck_while_cs_high: %0d cycles, required 0", cs_sck_viol);
        end
        checks++;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            errors++;
            $display("[TB] FAIL sb_leftover: %0d/%0d words outstanding, required 0/0", exp_a.size(), exp_b.size());
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tx_data_a = '0; tx_valid_a = 1'b0; tx_hold_a = 1'b0;
        tx_data_b = '0; tx_valid_b = 1'b0; tx_hold_b = 1'b0;
        cipo_sel = 1'b0; per_word = '0; resetn = 1'b0;
        test_reset();
        test_loopback();
        test_peripheral();
        test_back_to_back();
        test_reset_abort();
        test_fast();
`ifdef SPI_WORD_CONTROLLER_BURST_EN
        test_burst();
`endif
        test_final();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_word_controller.md
Name: spi_word_controller

Overview:
- SPI controller (initiator) that transfers one 64-bit little-endian word per transaction to a RAPcore SPIWord peripheral and simultaneously captures the returned word.
- Used by the bench/host-bridge logic and by multi-board builds where one RAPcore drives another board's SPI interface.
- Mode 0: SCK idles low, COPI changes on the falling edge, CIPO is sampled on the rising edge. Bytes are sent LSB-byte first; within each byte, bits are sent MSB first.

Parameters:
- WORD_BITS, 64: word width. Must be a multiple of 8.
- CLK_DIV, 4: SCK half-period in CLK cycles. Must be ≥1.
- CS_SETUP, 2: CLK cycles from CS falling to the first SCK rising edge. Must be ≥1.
- CS_HOLD, 2: CLK cycles from the last SCK falling edge to CS rising. Must be ≥1.

Ports:
- CLK  in  1  system clock
- resetn  in  1  synchronous active-low reset
- tx_data  in  WORD_BITS  word to send
- tx_valid  in  1  request a transfer
- tx_ready  out  1  controller can accept a word
- rx_data  out  WORD_BITS  word captured from CIPO
- rx_valid  out  1  one-cycle pulse; rx_data valid
- busy  out  1  transaction in progress (CS low or in GAP)
- SCK  out  1  SPI clock
- CS  out  1  chip select, active low
- COPI  out  1  controller out, peripheral in
- CIPO  in  1  peripheral out, controller in

Behaviour:
- Reset (resetn=0 at a CLK edge) sets: state IDLE, CS=1, SCK=0, COPI=0, rx_valid=0, rx_data=0, busy=0, tx_ready=1.
- Reset mid-transfer aborts immediately. No rx_valid pulse is produced and the partial word is discarded.
- States: IDLE → SETUP → XFER → HOLD → GAP → IDLE.
- IDLE:
  - tx_ready=1.
  - Accept occurs when tx_valid && tx_ready. tx_data is latched into the shift register.
  - On the next cycle: CS=0, COPI = first bit (tx_data[7]), tx_ready=0, busy=1.
- SETUP:
  - Lasts CS_SETUP cycles, then moves to XFER.
- XFER:
  - Runs WORD_BITS bit periods. Each bit period is CLK_DIV cycles with SCK=0, followed by CLK_DIV cycles with SCK=1.
  - CIPO is sampled into the receive shift register in the cycle SCK goes 0→1.
  - COPI advances to the next bit in the cycle SCK goes 1→0, except after the last bit.
  - Bit n (0..WORD_BITS-1) maps to word index 8*(n/8) + 7 - (n%8), for both tx and rx.
  - After the last falling edge: SCK=0, move to HOLD.
- HOLD:
  - Lasts CS_HOLD cycles with CS=0.
  - Then: CS=1, COPI=0, rx_data updated, rx_valid=1 for exactly one cycle, move to GAP.
- GAP:
  - CS=1 for CLK_DIV cycles; busy stays 1.
  - Then move to IDLE, with tx_ready=1 and busy=0.
- Timing:
  - Total CS-low time = CS_SETUP + 2*CLK_DIV*WORD_BITS + CS_HOLD cycles.
  - Accept-to-rx_valid latency = 1 + that total.
- tx_valid and tx_data are ignored while tx_ready=0. tx_data may change after accept.
- rx_data holds its value until the next completed transfer.
- No SCK edges occur while CS=1.

Optional Feature:
- Macro: SPI_WORD_CONTROLLER_BURST_EN
- With the macro defined:
  - Adds input tx_hold (1 bit), latched at accept.
  - If tx_hold=1, HOLD is skipped and CS stays 0. The rx_valid pulse is still issued, and the state moves to HELD.
  - In HELD: tx_ready=1, busy=1, SCK=0.
  - An accept in HELD goes directly to XFER (no SETUP) on the next cycle, with COPI loaded at the same time.
  - Accepting with tx_hold=0 ends the burst through the normal HOLD/GAP path.
  - HELD has no timeout.
- Without the macro: no tx_hold port, no HELD state, and every word is framed by its own CS.

Decomposition:
- Package spi_word_pkg contains:
  - state enum (IDLE, SETUP, XFER, HOLD, GAP, HELD)
  - WORD_BITS default constant
  - bit-order index function, shared with the peripheral-side bench model
- Sub-module spi_sck_gen: a CLK_DIV half-period counter that outputs SCK plus single-cycle rise/fall strobes, with enable and sync clear.

Test Plan:
1. Loopback (CIPO tied to COPI), CLK_DIV=2, tx_data=64'h0123456789ABCDEF → COPI first byte observed = 0xEF, MSB first. rx_valid pulses once, 1+2+256+2 cycles after accept. rx_data=64'h0123456789ABCDEF.
2. CIPO driven by a peripheral model returning 64'hFEDCBA9876543210 while sending 64'h0 → rx_data=64'hFEDCBA9876543210. COPI stays 0 throughout. Exactly 64 SCK rising edges while CS=0.
3. tx_valid held high continuously → back-to-back transfers separated by CS high for ≥CLK_DIV cycles. tx_ready is low during busy. A tx_data change mid-transfer does not alter COPI.
4. resetn asserted at bit 20 → the next cycle shows CS=1, SCK=0, COPI=0, tx_ready=1. No rx_valid. A new word then transfers correctly.
5. CLK_DIV=1, CS_SETUP=1, CS_HOLD=1 → SCK toggles every cycle. Word 64'hAAAA5555AAAA5555 loops back intact.
6. (BURST_EN) Two words with tx_hold=1 then 0 → CS stays low across both, with no SETUP before the second. Two rx_valid pulses; CS rises only after the second word's HOLD.
